// File: rtl/stim_pkg.sv
// Shared types and default widths for the stimulus source and its gap timer.
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_STEP   = 1;

endpackage

// File: rtl/stim_source_gap_timer.sv
// gap_timer: loadable down-counter timing the idle cycles between words.
// load wins over counting; expire is high while the count sits at zero.
module gap_timer
  import stim_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             count_en,
  output logic             expire
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/stim_source.sv
// stim_source: emits a bounded run of incrementing words over valid/ready with a programmable gap.
// Optional SRC_TRISTATE_EN adds bus_z, a copy of data driven only while valid is high.
//
// state   | meaning
// ST_IDLE | waiting for start; outputs quiet
// ST_SEND | word presented, valid held until accepted
// ST_GAP  | valid low, gap timer running down
// ST_DONE | one-cycle done pulse, then back to idle
module stim_source
  import stim_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int STEP   = DEF_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [GAP_W-1:0]  gap_cfg,
  input  logic [DATA_W-1:0] seed,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
`ifdef SRC_TRISTATE_EN
  output logic [DATA_W-1:0] bus_z,
`endif
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tmr_load;
  logic              tmr_expire;
  logic [GAP_W-1:0]  tmr_val;

  // Timer is only loaded when gap_q is nonzero, so gap_q-1 never underflows in use.
  assign tmr_val = gap_q - GAP_W'(1);

  gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count_en (state_q == ST_GAP),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    sent_d   = sent_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    tmr_load = 1'b0;

    if (abort) begin
      // Cancel beats everything, including a handshake in this same cycle.
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sent_d = '0;
            if (num_words != '0) begin
              state_d = ST_SEND;
              valid_d = 1'b1;
              busy_d  = 1'b1;
              data_d  = seed;
              rem_d   = num_words;
              gap_d   = gap_cfg;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (valid_q && ready) begin
            data_d = data_q + STEP_V;
            sent_d = sent_q + CNT_W'(1);
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d  = ST_GAP;
              valid_d  = 1'b0;
              tmr_load = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tmr_expire) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      sent_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data     = data_q;
  assign sent_cnt = sent_q;

`ifdef SRC_TRISTATE_EN
  assign bus_z = valid_q ? data_q : 'z;
`endif

endmodule
